stream_upsize: RTL and testbench
================================

Name: stream_upsize

Overview:
- Stream width upsizer. Packs T_DATA_RATIO consecutive narrow input beats into one wide output beat.
- Uses valid/ready handshakes on both sides.
- Sits between a narrow producer and a wide consumer. A packet ends early on s_last_i, and m_keep_o flags which lanes carry data.

Parameters:
- T_DATA_WIDTH, 4: width in bits of one input beat (one lane).
- T_DATA_RATIO, 2: input beats per output beat, must be >= 1. Output width = T_DATA_WIDTH*T_DATA_RATIO.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-high.
- s_data_i  in  T_DATA_WIDTH  input beat data.
- s_last_i  in  1  input beat is last of packet.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  block accepts input beat.
- m_data_o  out  T_DATA_WIDTH*T_DATA_RATIO  packed output word. Lane k = bits [k*W +: W].
- m_keep_o  out  T_DATA_RATIO  per-lane valid flags.
- m_last_o  out  1  output word ends a packet.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream accepts output word.

Behaviour:
- Reset (rst_n=1, asynchronous): lane index=0, assembly buffer and keep cleared, m_valid_o=0, m_last_o=0, m_data_o=0, m_keep_o=0, s_ready_o=0 while reset is held.
- Out of reset: s_ready_o = ~m_valid_o | m_ready_i (combinational). Input stalls only when the output register holds an unaccepted word.
- Input transfer = s_valid_i & s_ready_o. Output transfer = m_valid_o & m_ready_i.
- On input transfer:
  - s_data_i is written to lane[idx] of the assembly buffer and keep[idx] is set.
  - If idx==T_DATA_RATIO-1 or s_last_i=1, the word completes:
    - the buffer including the current beat moves to the output register;
    - m_valid_o=1 next cycle, m_last_o=s_last_i, m_keep_o=accumulated keep;
    - idx resets to 0 and the buffer and keep clear.
  - Otherwise idx increments and nothing is emitted.
- Lanes not written in a short (last-terminated) word are 0 in m_data_o with keep=0. Lane 0 is always the first beat (LSBs).
- Latency: m_valid_o rises the cycle after the completing input beat is accepted.
- Output register is held stable (data/keep/last) while m_valid_o=1 and m_ready_i=0.
- On output transfer with no simultaneous completion, m_valid_o drops to 0 next cycle.
- Simultaneous output transfer and completion: the new word loads immediately and m_valid_o stays 1. Full throughput: one output per T_DATA_RATIO input beats, no bubbles.
- Partial words are never emitted without s_last_i. Input idle time does not flush the buffer.
- s_data_i and s_last_i are ignored when no input transfer occurs.
- m_ready_i is allowed to toggle arbitrarily. The block never drops or duplicates beats.
- T_DATA_RATIO=1: every input beat emits one output word, keep=1.
- Reset mid-word or mid-stall: the partial buffer and any pending output word are discarded. The first beat after reset goes to lane 0.

Test Plan:
- W=4, R=2, m_ready_i=1: accept 0x3 then 0x1 (last=0) -> next cycle m_valid_o=1, m_data_o=0x13, m_keep_o=2'b11, m_last_o=0, for exactly one cycle.
- Accept 0x2 with s_last_i=1 at idx 0 -> m_data_o=0x02, m_keep_o=2'b01, m_last_o=1. Next word starts at lane 0.
- Backpressure: complete word 0x13 with m_ready_i=0 -> m_valid_o stays 1, data constant, s_ready_o=0, further s_valid_i beats not consumed. Raise m_ready_i -> word transfers and s_ready_o=1.
- Continuous s_valid_i=1, m_ready_i=1, beats 0x1,0x2,0x3,0x0 -> outputs 0x21 then 0x03 with no idle cycle between them, and s_ready_o constantly 1.
- Accept 0x1, assert rst_n=1 for one cycle, release, send 0x4,0x5 -> single output 0x54, keep 2'b11. 0x1 is never emitted, and all outputs are 0 during reset.
- Randomized: 1000 single beats separated by idle cycles with random data and random m_ready_i -> scoreboard matches every packed word, keep and last.

Source files
------------

// File: rtl/stream_upsize.sv
// Stream width upsizer: packs T_DATA_RATIO narrow input beats into one wide
// output word. Lane 0 holds the first beat of a word. A beat with s_last_i
// closes the word early, and the lanes it never reached stay zero with keep
// cleared. The output word sits in a register that is held while the
// consumer stalls. The input stalls only while that register holds a word
// the consumer has not taken yet.
module stream_upsize #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,      // asynchronous, active-high
  input  logic [T_DATA_WIDTH-1:0]              s_data_i,
  input  logic                                 s_last_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  output logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] m_data_o,
  output logic [T_DATA_RATIO-1:0]              m_keep_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i
);

  localparam int OW    = T_DATA_WIDTH * T_DATA_RATIO;
  localparam int IDX_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(T_DATA_RATIO - 1);

  // Assembly state
  logic [IDX_W-1:0]        idx_q,  idx_d;
  logic [OW-1:0]           buf_q,  buf_d;
  logic [T_DATA_RATIO-1:0] keep_q, keep_d;

  // Output register
  logic [OW-1:0]           m_data_q,  m_data_d;
  logic [T_DATA_RATIO-1:0] m_keep_q,  m_keep_d;
  logic                    m_last_q,  m_last_d;
  logic                    m_valid_q, m_valid_d;

  // Datapath helpers
  logic                    in_xfer_s;
  logic                    out_xfer_s;
  logic                    complete_s;
  logic [OW-1:0]           lane_buf_s;
  logic [T_DATA_RATIO-1:0] lane_keep_s;

  // Input is accepted whenever the output register is free or is being drained this cycle
  always_comb begin
    if (rst_n) begin
      s_ready_o = 1'b0;
    end else begin
      s_ready_o = ~m_valid_q | m_ready_i;
    end
  end

  // Merge the current beat into the buffer and work out whether it completes the word
  always_comb begin
    in_xfer_s   = s_valid_i & s_ready_o;
    out_xfer_s  = m_valid_q & m_ready_i;
    lane_buf_s  = buf_q;
    lane_keep_s = keep_q;
    lane_buf_s[int'(idx_q)*T_DATA_WIDTH +: T_DATA_WIDTH] = s_data_i;
    lane_keep_s[idx_q] = 1'b1;
    complete_s  = in_xfer_s & ((idx_q == LAST_IDX) | s_last_i);
  end

  // Next-state for assembly buffer and output register
  always_comb begin
    idx_d     = idx_q;
    buf_d     = buf_q;
    keep_d    = keep_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    if (complete_s) begin
      // The completed word moves out and the buffer restarts at lane 0.
      // A simultaneous drain of the old word is covered because the new
      // word overwrites the register and valid stays high.
      idx_d     = '0;
      buf_d     = '0;
      keep_d    = '0;
      m_data_d  = lane_buf_s;
      m_keep_d  = lane_keep_s;
      m_last_d  = s_last_i;
      m_valid_d = 1'b1;
    end else if (in_xfer_s) begin
      idx_d     = idx_q + IDX_W'(1);
      buf_d     = lane_buf_s;
      keep_d    = lane_keep_s;
      m_valid_d = m_valid_q & ~out_xfer_s;
    end else begin
      m_valid_d = m_valid_q & ~out_xfer_s;
    end
  end

  // State registers; reset discards any partial word and any pending output
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx_q     <= '0;
      buf_q     <= '0;
      keep_q    <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      keep_q    <= keep_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_keep_o  = m_keep_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_upsize.sv
// Testbench for stream_upsize (W=4, R=2). A monitor records every accepted
// input beat into a packet-level model. When the model closes a word (R beats
// or a last beat), it pushes the expected word into a queue. The same monitor
// pops and compares the queue whenever the DUT hands over an output word.
module tb_stream_upsize;

  localparam int W  = 4;
  localparam int R  = 2;
  localparam int OW = W * R;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [R-1:0]  k;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data_i;
  logic          s_last_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [OW-1:0] m_data_o;
  logic [R-1:0]  m_keep_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  exp_t       exp_q[$];
  logic [W-1:0] part_q[$];

  stream_upsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Downstream ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready_i = 1'b0;
      1:       m_ready_i = 1'b1;
      default: m_ready_i = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Monitor: reference model of the packet packing plus output scoreboard
  logic          stall_prev = 1'b0;
  exp_t          held;
  logic          want_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("reset_outputs", {m_valid_o, m_last_o, m_keep_o, m_data_o, s_ready_o}, 64'd0);
      exp_q.delete();
      part_q.delete();
      stall_prev = 1'b0;
      want_valid = 1'b0;
    end else begin
      if (want_valid) chk("latency_valid", m_valid_o, 1);
      want_valid = 1'b0;
      if (stall_prev) chk("stall_hold", {m_valid_o, m_data_o, m_keep_o, m_last_o}, {1'b1, held});
      if (m_valid_o && exp_q.size() == 0) begin
        chk("spurious_output", m_valid_o, 0);
      end else if (m_valid_o && m_ready_i) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_word", {m_data_o, m_keep_o, m_last_o}, e);
      end
      stall_prev = m_valid_o && !m_ready_i;
      held = '{d: m_data_o, k: m_keep_o, l: m_last_o};
      if (s_valid_i && s_ready_o) begin
        part_q.push_back(s_data_i);
        if (part_q.size() == R || s_last_i) begin
          exp_t e;
          e.d = '0;
          e.k = '0;
          for (int k = 0; k < part_q.size(); k++) begin
            e.d = e.d | (OW'(part_q[k]) << (k * W));
            e.k[k] = 1'b1;
          end
          e.l = s_last_i;
          exp_q.push_back(e);
          part_q.delete();
          want_valid = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded wait)
  task automatic send(input logic [W-1:0] d, input logic l);
    int  n;
    logic acc;
    s_data_i  = d;
    s_last_i  = l;
    s_valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      acc = s_ready_o;
      tick();
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    s_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; s_data_i = '0; s_last_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b1;
    #1;
    chk("reset_async", {m_valid_o, m_keep_o, m_data_o, s_ready_o}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();

    // Full word 0x3,0x1 -> 0x13, present for exactly one cycle
    send(4'h3, 1'b0);
    send(4'h1, 1'b0);
    #1;
    chk("t1_data", {m_valid_o, m_data_o, m_keep_o, m_last_o}, {1'b1, 8'h13, 2'b11, 1'b0});
    tick(); #1;
    chk("t1_one_cycle", m_valid_o, 0);

    // Short word terminated by last at lane 0
    send(4'h2, 1'b1);
    #1;
    chk("t2_short", {m_valid_o, m_data_o, m_keep_o, m_last_o}, {1'b1, 8'h02, 2'b01, 1'b1});
    tick();

    // Backpressure: word held, input stalled
    ready_mode = 0;
    tick();
    send(4'h3, 1'b0);
    send(4'h1, 1'b0);
    s_data_i = 4'h7; s_last_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall", {m_valid_o, m_data_o, s_ready_o}, {1'b1, 8'h13, 1'b0});
      tick();
    end
    s_valid_i = 1'b0;
    ready_mode = 1;
    tick(); #1;
    chk("t3_ready_back", s_ready_o, 1);
    tick(); #1;
    chk("t3_drained", m_valid_o, 0);

    // Continuous stream 1,2,3,0 -> 0x21 then 0x03
    s_valid_i = 1'b1; s_last_i = 1'b0;
    s_data_i = 4'h1; #1; chk("t4_ready", s_ready_o, 1); tick();
    s_data_i = 4'h2; #1; chk("t4_ready", s_ready_o, 1); tick();
    #1; chk("t4_word0", {m_valid_o, m_data_o}, {1'b1, 8'h21});
    s_data_i = 4'h3; chk("t4_ready", s_ready_o, 1); tick();
    s_data_i = 4'h0; #1; chk("t4_ready", s_ready_o, 1); tick();
    s_valid_i = 1'b0;
    #1; chk("t4_word1", {m_valid_o, m_data_o, m_keep_o}, {1'b1, 8'h03, 2'b11});
    tick();

    // Reset mid-word discards the partial beat
    send(4'h1, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("t5_in_reset", {m_valid_o, m_keep_o, m_data_o, s_ready_o}, 64'd0);
    tick();
    rst_n = 1'b0;
    tick();
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    #1;
    chk("t5_after_reset", {m_valid_o, m_data_o, m_keep_o}, {1'b1, 8'h54, 2'b11});
    tick();

    // Random single beats with idle gaps and random downstream ready
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(4'($urandom), ($urandom_range(0, 3) == 0) || (i == 999));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Drain
    ready_mode = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", m_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
